// File: rtl/bitbakery_pkg.sv
// bitbakery_pkg: shared FSM state codes and frame layout for the tx scheduler
package bitbakery_pkg;
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOAD  = 4'd1,
    SEND  = 4'd2,
    WAIT  = 4'd3,
    NEXT  = 4'd4,
    GAP   = 4'd5,
    ERROR = 4'd6
  } state_t;
  localparam int FRAME_LEN = 11;
  localparam int LAST_BYTE = FRAME_LEN - 1;
  typedef logic [FRAME_LEN-1:0][7:0] frame_t;
  // Byte 0 goes out first: D0, D1, D2, then the obstacle map low byte first.
  function automatic frame_t pack_frame(input logic [7:0] d0, input logic [7:0] d1,
                                        input logic [7:0] d2, input logic [63:0] map);
    return {map, d2, d1, d0};
  endfunction
endpackage

// File: rtl/contador_m.sv
// contador_m: saturating modulo-M cycle counter with clear and terminal flag
module contador_m #(
  parameter int M = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic at_end
);
  localparam int W = M > 1 ? $clog2(M) : 1;
  logic [W-1:0] q;
  always_ff @(posedge clock or posedge reset)
    if (reset) q <= '0;
    else if (clear) q <= '0;
    else if (count && !at_end) q <= q + W'(1);
  assign at_end = q == W'(M - 1);
endmodule

// File: rtl/bitbakery_tx_scheduler.sv
// bitbakery_tx_scheduler: sends 11-byte status frames to a byte transmitter with gap and timeout
module bitbakery_tx_scheduler
  import bitbakery_pkg::*;
#(
  parameter int GAP_CYCLES     = 50000,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  D0,
  input  logic [7:0]  D1,
  input  logic [7:0]  D2,
  input  logic [63:0] map_obstacles,
  input  logic        tx_pronto,
  output logic        tx_partida,
  output logic [7:0]  tx_dado,
  output logic        busy,
  output logic        frame_done,
  output logic        tx_error,
  output logic [3:0]  db_estado
);
  state_t state, state_next;
  frame_t snap;
  logic [3:0] idx;
  logic gap_end, timeout, last;
  contador_m #(.M(GAP_CYCLES)) gap_cnt (
    .clock(clock), .reset(reset), .clear(state != GAP), .count(state == GAP), .at_end(gap_end)
  );
  contador_m #(.M(TIMEOUT_CYCLES)) timeout_cnt (
    .clock(clock), .reset(reset), .clear(state != WAIT), .count(state == WAIT), .at_end(timeout)
  );
  assign last = idx == 4'(LAST_BYTE);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= IDLE;
      snap     <= '0;
      idx      <= '0;
      tx_error <= 1'b0;
    end else begin
      state    <= state_next;
      tx_error <= tx_error | (state_next == ERROR);
      if (state == LOAD) snap <= pack_frame(D0, D1, D2, map_obstacles);
      if (state == LOAD) idx <= '0;
      else if (state == NEXT && !last) idx <= idx + 4'd1;
    end
  // A changed D0 during the gap is urgent news and cuts the gap short.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = enable ? LOAD : IDLE;
      LOAD:    state_next = SEND;
      SEND:    state_next = WAIT;
      WAIT:    state_next = tx_pronto ? NEXT : timeout ? ERROR : WAIT;
      NEXT:    state_next = last ? GAP : SEND;
      GAP:     state_next = (enable && (gap_end || D0 != snap[0])) ? LOAD : gap_end ? IDLE : GAP;
      ERROR:   state_next = GAP;
      default: state_next = IDLE;
    endcase
  end
  assign tx_partida = state == SEND;
  assign tx_dado    = snap[idx];
  assign busy       = state inside {LOAD, SEND, WAIT, NEXT};
  assign frame_done = state == NEXT && last;
  assign db_estado  = state;
endmodule

// File: tb/tb_bitbakery_tx_scheduler.sv
// tb_bitbakery_tx_scheduler: scoreboard bench with a transmitter emulator and frame reference model
module tb_bitbakery_tx_scheduler;
  localparam int GAP = 200;
  localparam int TO = 40;
  localparam int DONE = 256;
  localparam int DROP_N = 25;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, tx_pronto = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic [63:0] map = '0;
  logic tx_partida, busy, frame_done, tx_error;
  logic [7:0] tx_dado;
  logic [3:0] db_estado;
  int errors = 0, checks = 0;
  int exp_q[$];
  int mon_sent = 0, mon_done = 0, n_sent = 0, fixed_delay = 5;

  always #5 clock = ~clock;

  bitbakery_tx_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .enable(enable), .D0(d0), .D1(d1), .D2(d2),
    .map_obstacles(map), .tx_pronto(tx_pronto), .tx_partida(tx_partida), .tx_dado(tx_dado),
    .busy(busy), .frame_done(frame_done), .tx_error(tx_error), .db_estado(db_estado)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference frame: D0, D1, D2, then map bytes least significant first.
  task automatic push_frame(input int n, input bit done);
    for (int k = 0; k < n; k++)
      exp_q.push_back(k == 0 ? int'(d0) : k == 1 ? int'(d1) : k == 2 ? int'(d2) : int'(map[8*(k-3) +: 8]));
    if (done) exp_q.push_back(DONE);
  endtask

  task automatic wait_sent(input int n);
    for (int k = 0; k < 5000 && mon_sent < n; k++) @(negedge clock);
    check("wait_sent", int'(mon_sent >= n), 1);
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 5000 && mon_done < n; k++) @(negedge clock);
    check("wait_done", int'(mon_done >= n), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_partida"}, tx_partida, 0);
    check({tag, "_tx_dado"}, tx_dado, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_tx_error"}, tx_error, 0);
    check({tag, "_db_estado"}, db_estado, 0);
  endtask

  // Monitor: every start pulse and frame_done is matched against the scoreboard queue.
  initial begin
    int cyc = 0, last_tx = 0;
    logic err_prev = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (tx_partida) begin
        mon_sent++;
        last_tx = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got %02h, required no transfer", tx_dado);
        end else check("tx_byte", tx_dado, exp_q.pop_front());
      end
      if (frame_done) begin
        mon_done++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got pulse, required none");
        end else check("frame_done", DONE, exp_q.pop_front());
      end
      if (tx_error && !err_prev) check("timeout_len", cyc - last_tx, TO + 1);
      err_prev = tx_error;
    end
  end

  // Byte transmitter emulator; the DROP_N-th byte never completes.
  initial begin
    int d;
    forever begin
      @(negedge clock);
      if (tx_partida) begin
        n_sent++;
        if (n_sent != DROP_N) begin
          d = fixed_delay != 0 ? fixed_delay : int'($urandom_range(2, 8));
          repeat (d - 1) @(negedge clock);
          tx_pronto = 1'b1;
          @(negedge clock);
          tx_pronto = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    d0 = 8'h13; d1 = 8'h45; d2 = 8'h8A; map = 64'h0807060504030201;
    push_frame(11, 1);
    enable = 1'b1;
    wait_sent(4);
    d1 = 8'h7F;
    wait_done(1);
    repeat (100) @(negedge clock);
    d0 = 8'h23;
    push_frame(11, 1);
    @(negedge clock);
    check("urgent_load", db_estado, 1);
    fixed_delay = 0;
    wait_sent(14);
    d2 = 8'($urandom);
    map = {$urandom, $urandom};
    push_frame(3, 0);
    for (int k = 0; k < 2000 && !tx_error; k++) @(negedge clock);
    check("tx_error_set", tx_error, 1);
    map = {$urandom, $urandom};
    push_frame(11, 1);
    wait_sent(30);
    enable = 1'b0;
    wait_done(3);
    repeat (GAP + 10) @(negedge clock);
    check("idle_busy", busy, 0);
    check("idle_state", db_estado, 0);
    check("error_sticky", tx_error, 1);
    fixed_delay = 8;
    push_frame(1, 0);
    enable = 1'b1;
    wait_sent(37);
    repeat (2) @(negedge clock);
    #3 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    enable = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("post_reset_state", db_estado, 0);
    fixed_delay = 0;
    d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
    map = {$urandom, $urandom};
    push_frame(11, 1);
    enable = 1'b1;
    wait_sent(40);
    enable = 1'b0;
    wait_done(4);
    repeat (5) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
